// File: rtl/cell_selector_if.sv
// Cursor/button inputs and the seed-grid output of the cell selector.
// The master drives the cursor and KEY; the slave (cell_selector) drives the grid.
interface cell_selector_if #(
  parameter int N     = 16,
  parameter int SEL_W = 4
);
  logic                    KEY;
  logic [SEL_W-1:0]        counterValue1;
  logic [SEL_W-1:0]        counterValue2;
  logic [N-1:0][N-1:0]     userInput;

  modport master (
    output KEY,
    output counterValue1,
    output counterValue2,
    input  userInput
  );

  modport slave (
    input  KEY,
    input  counterValue1,
    input  counterValue2,
    output userInput
  );
endinterface

// File: rtl/cell_selector.sv
// Editable NxN seed grid: each synchronized KEY press toggles the cell under the cursor.
// Cell flips on the 3rd edge that samples KEY low; output is purely registered.
module cell_selector #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input logic             clk,
  input logic             reset,
  cell_selector_if.slave  bus
);

  logic                r_k1;
  logic                r_k2;
  logic                r_kp;
  logic [N-1:0][N-1:0] r_grid;
  logic                w_press;

  // Falling edge of the synchronized button, one cycle wide.
  assign w_press = r_kp & ~r_k2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k1   <= 1'b1;
      r_k2   <= 1'b1;
      r_kp   <= 1'b1;
      r_grid <= '0;
    end else begin
      r_k1 <= bus.KEY;
      r_k2 <= r_k1;
      r_kp <= r_k2;
      if (w_press)
        r_grid[bus.counterValue1][bus.counterValue2] <= ~r_grid[bus.counterValue1][bus.counterValue2];
    end
  end

  assign bus.userInput = r_grid;

endmodule

// File: tb/tb_cell_selector.sv
// Randomized and directed check of cell_selector against a history-based grid model.
module tb_cell_selector;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   en = 1'b0;

  always #5 clk = ~clk;

  cell_selector_if #(.N(16), .SEL_W(4)) bus ();

  cell_selector #(.N(16), .SEL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: a cell toggles at edge E when KEY was sampled high at E-3 and low at E-2.
  logic [255:0] m_grid;
  bit           hist[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_grid = '0;
      hist   = '{1'b1, 1'b1, 1'b1};
    end else begin
      if (hist[1] == 1'b0 && hist[2] == 1'b1)
        m_grid[16 * int'(bus.counterValue1) + int'(bus.counterValue2)] ^= 1'b1;
      hist.push_front(bus.KEY);
      while (hist.size() > 3) void'(hist.pop_back());
    end
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) chk("cycle_model", bus.userInput, m_grid);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_cv(input int r, input int c);
    bus.counterValue1 = 4'(r);
    bus.counterValue2 = 4'(c);
  endtask

  logic [255:0] exp;

  initial begin
    reset   = 1'b0;
    bus.KEY = 1'b1;
    set_cv(0, 0);
    @(posedge clk);
    #2;
    chk("reset_zero", bus.userInput, '0);
    reset = 1'b1;
    en    = 1'b1;

    repeat (3) begin
      cyc(1);
      chk("idle_zero", bus.userInput, '0);
    end

    // Single press at (1,5), held five edges.
    set_cv(1, 5);
    bus.KEY = 1'b0;
    cyc(2);
    chk("press_latency", bus.userInput, '0);
    cyc(1);
    exp = '0; exp[21] = 1'b1;
    chk("press_flip", bus.userInput, exp);
    cyc(2);
    chk("press_hold", bus.userInput, exp);

    bus.KEY = 1'b1;
    cyc(4);
    bus.KEY = 1'b0;
    cyc(4);
    chk("self_inverse", bus.userInput, '0);
    bus.KEY = 1'b1;
    cyc(4);

    // Corner cells.
    set_cv(15, 0);
    bus.KEY = 1'b0;
    cyc(4);
    bus.KEY = 1'b1;
    cyc(4);
    set_cv(0, 15);
    bus.KEY = 1'b0;
    cyc(4);
    bus.KEY = 1'b1;
    cyc(4);
    exp = '0; exp[240] = 1'b1; exp[15] = 1'b1;
    chk("corners", bus.userInput, exp);

    // Cursor wiggling while held: only the cursor at the toggle edge (15,0) flips.
    bus.KEY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) set_cv(15, 0);
      else            set_cv(1, 5);
      cyc(1);
    end
    bus.KEY = 1'b1;
    cyc(4);
    exp = '0; exp[15] = 1'b1;
    chk("cursor_wiggle", bus.userInput, exp);

    // Async reset mid-cycle with KEY held low, then re-press after release.
    bus.KEY = 1'b0;
    set_cv(7, 9);
    cyc(1);
    reset = 1'b0;
    #1;
    chk("async_reset", bus.userInput, '0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    exp = '0; exp[121] = 1'b1;
    chk("repress_after_reset", bus.userInput, exp);
    bus.KEY = 1'b1;
    cyc(4);

    // Random cursor movement and button activity, including one-cycle glitches.
    for (int i = 0; i < 800; i++) begin
      set_cv($urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus.KEY = ~bus.KEY;
      cyc(1);
    end
    bus.KEY = 1'b1;
    cyc(4);

    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
